// File: rtl/mbp_pkg.sv
// Shared types for the branch-resolution tracker.
//   mbp_entry_t     : queued fetch record {vpc, pred}
//   bht_update_t    : update record driven back into the BHT
//   resolve_state_e : resolve FSM states
//   lowest_set_idx  : index of the lowest set bit of a slot mask
package mbp_pkg;

  localparam int unsigned Vlen = 32;
  localparam int unsigned Ipf  = 2;  // instructions per fetch
  localparam int unsigned IdxW = (Ipf > 1) ? $clog2(Ipf) : 1;

  typedef struct packed {
    logic [Vlen-1:0] vpc;
    logic [Ipf-1:0]  pred;
  } mbp_entry_t;

  typedef struct packed {
    logic            valid;
    logic [Vlen-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef enum logic [0:0] {
    StIdle,
    StUpdate
  } resolve_state_e;

  // Returns 0 for an empty mask; callers only use the result when the mask is non-zero.
  function automatic logic [IdxW-1:0] lowest_set_idx(logic [Ipf-1:0] mask);
    lowest_set_idx = '0;
    for (int i = Ipf - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set_idx = IdxW'(i);
    end
  endfunction

endpackage

// File: rtl/mbp_resolve_unit_if.sv
// Fetch / resolve / update bundle of the branch-resolution tracker.
//   fetch_*       : prediction push (valid/ready)
//   resolve_*     : resolution of the oldest queued fetch (valid/ready)
//   bht_update_o, mispredict_o : per-branch update stream
//   order_err_o, branch_cnt_o, mispredict_cnt_o : status and statistics
// slave = the tracker, master = the environment driving it.
interface mbp_resolve_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import mbp_pkg::*;

  logic                 fetch_valid_i;
  logic                 fetch_ready_o;
  logic [Vlen-1:0]      fetch_vpc_i;
  logic [Ipf-1:0]       prediction_i;
  logic                 resolve_valid_i;
  logic                 resolve_ready_o;
  logic [Ipf-1:0]       resolve_mask_i;
  logic [Ipf-1:0]       resolve_taken_i;
  bht_update_t          bht_update_o;
  logic                 mispredict_o;
  logic                 order_err_o;
  logic [CNT_W-1:0]     branch_cnt_o;
  logic [CNT_W-1:0]     mispredict_cnt_o;

  modport slave (
    input  fetch_valid_i, fetch_vpc_i, prediction_i,
    input  resolve_valid_i, resolve_mask_i, resolve_taken_i,
    output fetch_ready_o, resolve_ready_o, bht_update_o, mispredict_o,
    output order_err_o, branch_cnt_o, mispredict_cnt_o
  );

  modport master (
    output fetch_valid_i, fetch_vpc_i, prediction_i,
    output resolve_valid_i, resolve_mask_i, resolve_taken_i,
    input  fetch_ready_o, resolve_ready_o, bht_update_o, mispredict_o,
    input  order_err_o, branch_cnt_o, mispredict_cnt_o
  );

endinterface

// File: rtl/mbp_pred_fifo.sv
// DEPTH-entry circular buffer of fetch records.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : empty the buffer (wins over push/pop)
//   push_i, wdata_i : write at tail (ignored when full)
//   pop_i         : advance head (ignored when empty)
//   full_o, empty_o, head_o : status and oldest entry
module mbp_pred_fifo
  import mbp_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  mbp_entry_t wdata_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output mbp_entry_t head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  mbp_entry_t        r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;
  logic              w_push, w_pop;

  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/mbp_resolve_unit.sv
// Branch-resolution tracker: queues per-fetch predictions, and on each
// resolution replays one BHT update per resolved slot (lowest slot first),
// flagging mispredictions and keeping saturating statistics.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : drop queued fetches and abort an update burst
//   bus_io        : fetch / resolve / update bundle (slave side)
module mbp_resolve_unit
  import mbp_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  mbp_resolve_unit_if.slave   bus_io
);

  logic           w_full, w_empty, w_push, w_pop;
  mbp_entry_t     w_head, w_wdata;
  resolve_state_e r_state, w_state_d;

  logic [Ipf-1:0]  r_mask, w_mask_d, r_pred, w_pred_d, r_taken, w_taken_d;
  logic [Vlen-1:0] r_vpc, w_vpc_d;
  logic [Ipf-1:0]  w_src_mask, w_src_pred, w_src_taken, w_mask_rem;
  logic [Vlen-1:0] w_src_vpc;
  logic [IdxW-1:0] w_idx;
  logic            w_issue;

  bht_update_t     r_upd, w_upd_d;
  logic            r_misp, w_misp_d;
  logic            r_order_err, w_order_err_d;
  logic [CNT_W-1:0] r_branch_cnt, r_misp_cnt;

  assign w_push          = bus_io.fetch_valid_i && !w_full;
  assign w_wdata.vpc     = bus_io.fetch_vpc_i;
  assign w_wdata.pred    = bus_io.prediction_i;

  mbp_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .wdata_i (w_wdata),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .head_o  (w_head)
  );

  // In Idle the first update is issued straight from the resolve inputs and
  // the head entry, so it is visible the cycle after acceptance.
  always_comb begin
    w_src_mask  = r_mask;
    w_src_vpc   = r_vpc;
    w_src_pred  = r_pred;
    w_src_taken = r_taken;
    if (r_state == StIdle) begin
      w_src_mask  = bus_io.resolve_mask_i;
      w_src_vpc   = w_head.vpc;
      w_src_pred  = w_head.pred;
      w_src_taken = bus_io.resolve_taken_i;
    end
    w_idx      = lowest_set_idx(w_src_mask);
    w_mask_rem = w_src_mask & ~(Ipf'(1) << w_idx);

    w_state_d     = r_state;
    w_mask_d      = r_mask;
    w_vpc_d       = r_vpc;
    w_pred_d      = r_pred;
    w_taken_d     = r_taken;
    w_order_err_d = r_order_err;
    w_pop         = 1'b0;
    w_issue       = 1'b0;

    if (flush_i) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus_io.resolve_valid_i) begin
            if (w_empty) begin
              w_order_err_d = 1'b1;
            end else if (bus_io.resolve_mask_i == '0) begin
              w_pop = 1'b1;
            end else begin
              w_issue   = 1'b1;
              w_mask_d  = w_mask_rem;
              w_vpc_d   = w_src_vpc;
              w_pred_d  = w_src_pred;
              w_taken_d = w_src_taken;
              w_state_d = StUpdate;
            end
          end
        end
        StUpdate: begin
          // The update on the outputs this cycle is the last one once the mask is empty.
          if (r_mask != '0) begin
            w_issue  = 1'b1;
            w_mask_d = w_mask_rem;
          end else begin
            w_pop     = 1'b1;
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    w_upd_d  = '0;
    w_misp_d = 1'b0;
    if (w_issue) begin
      w_upd_d.valid = 1'b1;
      w_upd_d.pc    = w_src_vpc + (Vlen'(w_idx) << 1);
      w_upd_d.taken = w_src_taken[w_idx];
      w_misp_d      = w_src_pred[w_idx] ^ w_src_taken[w_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_mask       <= '0;
      r_vpc        <= '0;
      r_pred       <= '0;
      r_taken      <= '0;
      r_upd        <= '0;
      r_misp       <= 1'b0;
      r_order_err  <= 1'b0;
      r_branch_cnt <= '0;
      r_misp_cnt   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_mask      <= w_mask_d;
      r_vpc       <= w_vpc_d;
      r_pred      <= w_pred_d;
      r_taken     <= w_taken_d;
      r_upd       <= w_upd_d;
      r_misp      <= w_misp_d;
      r_order_err <= w_order_err_d;
      if (w_issue && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_issue && w_misp_d && (r_misp_cnt != '1)) r_misp_cnt <= r_misp_cnt + CNT_W'(1);
    end
  end

  assign bus_io.fetch_ready_o    = !w_full;
  assign bus_io.resolve_ready_o  = (r_state == StIdle);
  assign bus_io.bht_update_o     = r_upd;
  assign bus_io.mispredict_o     = r_misp;
  assign bus_io.order_err_o      = r_order_err;
  assign bus_io.branch_cnt_o     = r_branch_cnt;
  assign bus_io.mispredict_cnt_o = r_misp_cnt;

endmodule

// File: tb/tb_mbp_resolve_unit.sv
// Bench for mbp_resolve_unit: directed stimulus pushes hand-computed
// expected updates into a scoreboard; a negedge monitor pops and compares
// every update the DUT presents. A second instance with 2-bit counters
// covers saturation.
module tb_mbp_resolve_unit;
  import mbp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush_s = 1'b0;
  always #5 clk = ~clk;

  mbp_resolve_unit_if #(.CNT_W(32)) bus ();
  mbp_resolve_unit_if #(.CNT_W(2))  bus_s ();

  mbp_resolve_unit #(.DEPTH(8), .CNT_W(32)) dut (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .bus_io (bus)
  );
  mbp_resolve_unit #(.DEPTH(8), .CNT_W(2)) dut_s (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (flush_s), .bus_io (bus_s)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        misp;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic taken, input logic misp);
    exp_t e;
    e.pc = pc; e.taken = taken; e.misp = misp;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.bht_update_o.valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_update", {32'h0, bus.bht_update_o.pc}, 64'hffff_ffff_ffff_ffff);
      end else begin
        e = exp_q.pop_front();
        chk("upd_pc", bus.bht_update_o.pc, e.pc);
        chk("upd_taken", bus.bht_update_o.taken, e.taken);
        chk("upd_misp", bus.mispredict_o, e.misp);
      end
    end
  end

  task automatic push(input logic [31:0] vpc, input logic [1:0] pred);
    int n = 0;
    while (!bus.fetch_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("push_ready", bus.fetch_ready_o, 1);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_vpc_i   = vpc;
    bus.prediction_i  = pred;
    @(posedge clk); #1;
    bus.fetch_valid_i = 1'b0;
  endtask

  task automatic resolve(input logic [1:0] mask, input logic [1:0] taken);
    int n = 0;
    while (!bus.resolve_ready_o && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("resolve_ready", bus.resolve_ready_o, 1);
    bus.resolve_valid_i = 1'b1;
    bus.resolve_mask_i  = mask;
    bus.resolve_taken_i = taken;
    @(posedge clk); #1;
    bus.resolve_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    bus.fetch_valid_i = 0; bus.fetch_vpc_i = '0; bus.prediction_i = '0;
    bus.resolve_valid_i = 0; bus.resolve_mask_i = '0; bus.resolve_taken_i = '0;
    bus_s.fetch_valid_i = 0; bus_s.fetch_vpc_i = '0; bus_s.prediction_i = '0;
    bus_s.resolve_valid_i = 0; bus_s.resolve_mask_i = '0; bus_s.resolve_taken_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_fetch_ready", bus.fetch_ready_o, 1);
    chk("rst_resolve_ready", bus.resolve_ready_o, 1);
    chk("rst_update", bus.bht_update_o, 0);
    chk("rst_misp", bus.mispredict_o, 0);
    chk("rst_order_err", bus.order_err_o, 0);
    chk("rst_branch_cnt", bus.branch_cnt_o, 0);
    chk("rst_misp_cnt", bus.mispredict_cnt_o, 0);

    // Single branch, mispredicted.
    push(32'h8000_0000, 2'b01);
    expect_upd(32'h8000_0000, 1'b0, 1'b1);
    resolve(2'b01, 2'b00);
    @(negedge clk);
    chk("single_latency_valid", bus.bht_update_o.valid, 1);
    chk("single_rr_low", bus.resolve_ready_o, 0);
    @(negedge clk);
    chk("single_rr_high", bus.resolve_ready_o, 1);
    chk("single_valid_clear", bus.bht_update_o.valid, 0);
    chk("single_branch_cnt", bus.branch_cnt_o, 1);
    chk("single_misp_cnt", bus.mispredict_cnt_o, 1);

    // Two slots.
    push(32'h0000_1000, 2'b11);
    expect_upd(32'h0000_1000, 1'b0, 1'b1);
    expect_upd(32'h0000_1002, 1'b1, 1'b0);
    resolve(2'b11, 2'b10);
    lows = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bus.resolve_ready_o) lows++;
    end
    chk("two_rr_low_cycles", lows, 2);
    chk("two_branch_cnt", bus.branch_cnt_o, 3);
    chk("two_misp_cnt", bus.mispredict_cnt_o, 2);

    // Full queue, drain with mask=0 in 8 consecutive cycles.
    for (int i = 0; i < 8; i++) push(32'h2000 + 32'(i) * 32'h10, 2'b01);
    @(negedge clk);
    chk("full_fetch_ready", bus.fetch_ready_o, 0);
    @(posedge clk); #1;
    bus.resolve_valid_i = 1'b1;
    bus.resolve_mask_i  = 2'b00;
    repeat (8) begin
      @(posedge clk); #1;
    end
    bus.resolve_valid_i = 1'b0;
    @(negedge clk);
    chk("drain_fetch_ready", bus.fetch_ready_o, 1);
    chk("drain_order_err", bus.order_err_o, 0);
    // Refill; ready must drop exactly after the 8th push if the drain was complete.
    for (int i = 0; i < 8; i++) push(32'h4000 + 32'(i) * 32'h10, 2'b01);
    @(negedge clk);
    chk("refill_fetch_ready", bus.fetch_ready_o, 0);
    for (int i = 0; i < 8; i++) begin
      expect_upd(32'h4000 + 32'(i) * 32'h10, 1'b1, 1'b0);
      resolve(2'b01, 2'b01);
    end
    repeat (3) @(negedge clk);
    chk("order_branch_cnt", bus.branch_cnt_o, 11);
    chk("order_misp_cnt", bus.mispredict_cnt_o, 2);

    // Flush on the first update cycle of a 2-branch burst.
    push(32'h5000, 2'b00);
    push(32'h5100, 2'b00);
    push(32'h5200, 2'b00);
    expect_upd(32'h5000, 1'b1, 1'b1);
    resolve(2'b11, 2'b11);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", bus.bht_update_o.valid, 0);
    chk("flush_fetch_ready", bus.fetch_ready_o, 1);
    chk("flush_resolve_ready", bus.resolve_ready_o, 1);
    chk("flush_branch_cnt", bus.branch_cnt_o, 12);
    chk("flush_misp_cnt", bus.mispredict_cnt_o, 3);
    repeat (3) @(negedge clk);
    chk("flush_order_err", bus.order_err_o, 0);

    // Resolve with the queue empty.
    resolve(2'b01, 2'b01);
    @(negedge clk);
    chk("empty_order_err", bus.order_err_o, 1);
    chk("empty_no_update", bus.bht_update_o.valid, 0);

    // PC wrap on slot 1.
    push(32'hFFFF_FFFE, 2'b10);
    expect_upd(32'h0000_0000, 1'b1, 1'b0);
    resolve(2'b10, 2'b10);
    repeat (3) @(negedge clk);
    chk("wrap_branch_cnt", bus.branch_cnt_o, 13);
    chk("wrap_misp_cnt", bus.mispredict_cnt_o, 3);
    chk("order_err_sticky", bus.order_err_o, 1);

    // Saturation with 2-bit counters: five mispredictions.
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus_s.fetch_valid_i = 1'b1;
      bus_s.fetch_vpc_i   = 32'h40;
      bus_s.prediction_i  = 2'b00;
      @(posedge clk); #1;
      bus_s.fetch_valid_i   = 1'b0;
      bus_s.resolve_valid_i = 1'b1;
      bus_s.resolve_mask_i  = 2'b01;
      bus_s.resolve_taken_i = 2'b01;
      @(posedge clk); #1;
      bus_s.resolve_valid_i = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    chk("sat_misp_cnt", bus_s.mispredict_cnt_o, 3);
    chk("sat_branch_cnt", bus_s.branch_cnt_o, 3);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
